// File: rtl/hsem_task_dispatch.sv
// rtl/hsem_task_dispatch.sv - round-robin task dispatcher with completion watchdog
//
// Merges task-register writes into a pending set. Offers pending tasks to the
// core one at a time in round-robin order and watches each running task with
// a timeout. A timed-out task is re-queued, and the timeout is recorded in a
// sticky error flag. Completed tasks are counted with a saturating counter.
//
// Ports:
//   hclk, hresetn  clock, asynchronous active-low reset
//   tsk_stat       task status register value (bit i = task i requested)
//   tsk_upd        pulses in the cycle the task register is written
//   tsk_valid      task offer valid
//   tsk_id         id of the offered / running task
//   tsk_ack        core accepts the offered task
//   tsk_done       core finished the running task (single-cycle pulse)
//   err_clr        clears to_err
//   pend           pending task set
//   busy           dispatcher not idle
//   to_err         sticky timeout flag
//   done_cnt       saturating completed-task counter
module hsem_task_dispatch #(
  parameter int TASK_NUM = 32,
  parameter int ID_W     = 5,
  parameter int TIMEOUT  = 1024,
  parameter int TO_W     = 11
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [TASK_NUM-1:0] tsk_stat,
  input  logic                tsk_upd,
  output logic                tsk_valid,
  output logic [ID_W-1:0]     tsk_id,
  input  logic                tsk_ack,
  input  logic                tsk_done,
  input  logic                err_clr,
  output logic [TASK_NUM-1:0] pend,
  output logic                busy,
  output logic                to_err,
  output logic [15:0]         done_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]            state;
  logic                  upd_d;
  logic [ID_W-1:0]       ptr;
  logic [TO_W-1:0]       timer;
  logic [TASK_NUM-1:0]   id_mask;
  logic [TASK_NUM-1:0]   set_v;
  logic [TASK_NUM-1:0]   clr_v;
  logic [TASK_NUM-1:0]   rq_v;
  logic [TASK_NUM-1:0]   rot;
  logic [2*TASK_NUM-1:0] dbl;
  logic [ID_W-1:0]       sel_id;
  logic                  ack_ok;
  logic                  timeout;

  assign tsk_valid = (state == ST_OFFER);
  assign busy      = (state != ST_IDLE);

  assign ack_ok  = (state == ST_OFFER) && tsk_ack;
  // A done in the final cycle takes precedence over the timeout.
  assign timeout = (state == ST_BUSY) && !tsk_done && (timer == TO_W'(TIMEOUT - 1));

  assign id_mask = TASK_NUM'(1) << tsk_id;

  // The register value settles one cycle after the write strobe.
  assign set_v = upd_d   ? tsk_stat : '0;
  assign clr_v = ack_ok  ? id_mask  : '0;
  assign rq_v  = timeout ? id_mask  : '0;

  // Rotate pend so bit 0 of rot corresponds to ptr+1; the lowest set bit of
  // rot is then the next task in round-robin order (ptr itself is checked last).
  assign dbl = {pend, pend};
  assign rot = TASK_NUM'(dbl >> (int'(ptr) + 1));

  always_comb begin
    sel_id = '0;
    for (int j = TASK_NUM - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sel_id = ID_W'((int'(ptr) + 1 + j) % TASK_NUM);
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      upd_d    <= 1'b0;
      pend     <= '0;
      tsk_id   <= '0;
      ptr      <= ID_W'(TASK_NUM - 1);
      timer    <= '0;
      to_err   <= 1'b0;
      done_cnt <= '0;
    end else begin
      upd_d <= tsk_upd;
      // Set wins over clear so a re-request of the acked task is kept.
      pend  <= (pend & ~clr_v) | set_v | rq_v;

      case (state)
        ST_IDLE: begin
          if (|pend) begin
            tsk_id <= sel_id;
            state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (tsk_ack) begin
            ptr   <= tsk_id;
            timer <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          timer <= timer + TO_W'(1);
          if (tsk_done) begin
            if (done_cnt != 16'hFFFF) begin
              done_cnt <= done_cnt + 16'd1;
            end
            state <= ST_IDLE;
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (timeout) begin
        to_err <= 1'b1;
      end else if (err_clr) begin
        to_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hsem_task_dispatch.sv
// tb/tb_hsem_task_dispatch.sv - directed self-checking bench for hsem_task_dispatch
module tb_hsem_task_dispatch;

  logic        hclk;
  logic        hresetn;
  logic [31:0] tsk_stat;
  logic        tsk_upd;
  logic        tsk_valid;
  logic [4:0]  tsk_id;
  logic        tsk_ack;
  logic        tsk_done;
  logic        err_clr;
  logic [31:0] pend;
  logic        busy;
  logic        to_err;
  logic [15:0] done_cnt;

  int checks;
  int failures;

  hsem_task_dispatch #(
    .TASK_NUM (32),
    .ID_W     (5),
    .TIMEOUT  (16),
    .TO_W     (5)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .tsk_stat  (tsk_stat),
    .tsk_upd   (tsk_upd),
    .tsk_valid (tsk_valid),
    .tsk_id    (tsk_id),
    .tsk_ack   (tsk_ack),
    .tsk_done  (tsk_done),
    .err_clr   (err_clr),
    .pend      (pend),
    .busy      (busy),
    .to_err    (to_err),
    .done_cnt  (done_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] val);
    tsk_stat = val;
    tsk_upd  = 1'b1;
    tick();
    tsk_upd  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tsk_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, tsk_valid}, 32'd1);
  endtask

  task automatic ack();
    tsk_ack = 1'b1;
    tick();
    tsk_ack = 1'b0;
  endtask

  task automatic done();
    tsk_done = 1'b1;
    tick();
    tsk_done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hresetn  = 1'b0;
    tsk_stat = '0;
    tsk_upd  = 1'b0;
    tsk_ack  = 1'b0;
    tsk_done = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    hresetn = 1'b1;
    tick();

    // 1: idle after reset; stray ack/done must be ignored
    check("rst_valid", {31'd0, tsk_valid}, 32'd0);
    check("rst_id", {27'd0, tsk_id}, 32'd0);
    check("rst_pend", pend, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_to_err", {31'd0, to_err}, 32'd0);
    check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tsk_ack  = (i == 5);
      tsk_done = (i == 9);
      tick();
      check("idle_valid", {31'd0, tsk_valid}, 32'd0);
    end
    tsk_ack  = 1'b0;
    tsk_done = 1'b0;
    check("idle_done_cnt", {16'd0, done_cnt}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2: write 0x5, exact latency, ids 0 then 2
    wr(32'h5);                                   // now cycle N+1
    check("lat_pend_n1", pend, 32'd0);
    tick();                                      // N+2
    check("lat_pend_n2", pend, 32'h5);
    check("lat_valid_n2", {31'd0, tsk_valid}, 32'd0);
    tick();                                      // N+3
    check("lat_valid_n3", {31'd0, tsk_valid}, 32'd1);
    check("t2_id0", {27'd0, tsk_id}, 32'd0);
    ack();
    check("t2_valid_drop", {31'd0, tsk_valid}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_pend_after_ack", pend, 32'h4);
    tick();
    tick();
    done();                                      // M+1
    check("b2b_idle", {31'd0, busy}, 32'd0);
    tick();                                      // M+2
    check("b2b_valid", {31'd0, tsk_valid}, 32'd1);
    check("t2_id2", {27'd0, tsk_id}, 32'd2);
    ack();
    tick();
    done();
    tick();
    check("t2_pend", pend, 32'd0);
    check("t2_done_cnt", {16'd0, done_cnt}, 32'd2);

    // 3: wrap-around after dispatching id 31
    wr(32'h8000_0000);
    wait_valid("t3_v31");
    check("t3_id31", {27'd0, tsk_id}, 32'd31);
    ack();
    done();
    wr(32'h8000_0001);
    wait_valid("t3_va");
    check("t3_first_id0", {27'd0, tsk_id}, 32'd0);
    ack();
    check("t3_pend", pend, 32'h8000_0000);
    done();
    wait_valid("t3_vb");
    check("t3_then_id31", {27'd0, tsk_id}, 32'd31);
    ack();
    done();
    check("t3_done_cnt", {16'd0, done_cnt}, 32'd5);

    // 4: timeout re-queues id 3; err_clr coincident with timeout loses
    wr(32'h8);
    wait_valid("t4_v");
    check("t4_id3", {27'd0, tsk_id}, 32'd3);
    ack();                                       // first BUSY cycle, timer 0
    for (int i = 0; i < 15; i++) tick();         // timer == 15 now
    check("t4_pre_to_err", {31'd0, to_err}, 32'd0);
    check("t4_pre_busy", {31'd0, busy}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_to_err", {31'd0, to_err}, 32'd1);
    check("t4_requeue", pend, 32'h8);
    check("t4_idle", {31'd0, busy}, 32'd0);
    wait_valid("t4_rv");
    check("t4_reoffer_id", {27'd0, tsk_id}, 32'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr", {31'd0, to_err}, 32'd0);

    // 5: done on the exact timeout cycle wins
    ack();
    for (int i = 0; i < 15; i++) tick();
    done();
    check("t5_to_err", {31'd0, to_err}, 32'd0);
    check("t5_done_cnt", {16'd0, done_cnt}, 32'd6);
    check("t5_pend", pend, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);

    // 6: merge during BUSY, then asynchronous reset
    wr(32'hF0);
    wait_valid("t6_v");
    check("t6_id4", {27'd0, tsk_id}, 32'd4);
    ack();
    wr(32'hF0);
    tick();
    check("t6_merge_pend", pend, 32'hF0);
    check("t6_still_busy", {31'd0, busy}, 32'd1);
    check("t6_id_stable", {27'd0, tsk_id}, 32'd4);
    #2;
    hresetn = 1'b0;
    #1;
    check("t6_rst_pend", pend, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_valid", {31'd0, tsk_valid}, 32'd0);
    check("t6_rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    tick();
    hresetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
